// File: rtl/fp_decode.sv
// fp_decode: sequential decoder of a tiny float word (S,E,F) into a 12-bit
// two's-complement linear value D = (S ? -1 : +1) * F * 2^E.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid/in_ready    input handshake; S/E/F are sampled on the accepting edge
//   S, E, F              sign, 3-bit exponent, 4-bit unsigned significand
//   out_valid/out_ready  output handshake; D is held stable while out_valid is high
//   D                    decoded value; keeps its last value until the next decode
//   busy                 high whenever a decode is in flight or waiting in DONE
module fp_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        S,
    input  logic [2:0]  E,
    input  logic [3:0]  F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] D,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FORM  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  r_state;
    logic        r_sign;
    logic [11:0] r_mag;
    logic [2:0]  r_cnt;
    logic [11:0] r_d;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign D         = r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_mag   <= 12'd0;
            r_cnt   <= 3'd0;
            r_d     <= 12'd0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign  <= S;
                    r_mag   <= {8'd0, F};
                    r_cnt   <= E;
                    r_state <= (E != 3'd0) ? SHIFT : FORM;
                end
                SHIFT: begin
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt - 3'd1;
                    // last shift happens as the counter steps from 1 to 0
                    if (r_cnt == 3'd1) r_state <= FORM;
                end
                FORM: begin
                    // negating zero yields zero, so -0 collapses to 12'h000
                    r_d     <= r_sign ? (~r_mag + 12'd1) : r_mag;
                    r_state <= DONE;
                end
                default: if (out_ready) r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_decode.sv
// tb_fp_decode: directed and exhaustive self-checking bench for fp_decode.
module tb_fp_decode;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        S = 1'b0;
    logic [2:0]  E = 3'd0;
    logic [3:0]  F = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] D;
    logic        busy;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fp_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
        int v;
        v = int'(f) << e;
        if (s) v = -v;
        return v[11:0];
    endfunction

    task automatic scramble();
        S = 1'($urandom);
        E = 3'($urandom);
        F = 4'($urandom);
    endtask

    task automatic run(input logic s, input logic [2:0] e, input logic [3:0] f,
                       input logic [11:0] exp, input int gap, input int hold);
        int lat;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        S = s; E = e; F = f; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'($urandom);
        scramble();
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            scramble();
        end
        check("latency", 32'(lat), 32'(e) + 32'd1);
        check("D", 32'(D), 32'(exp));
        check("busy_done", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            scramble();
            check("D_hold", 32'(D), 32'(exp));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 3'd0, 4'd5,  12'h005, 0, 0);
        run(1'b1, 3'd7, 4'd15, 12'h880, 0, 0);
        run(1'b0, 3'd7, 4'd15, 12'h780, 1, 0);
        run(1'b1, 3'd4, 4'd0,  12'h000, 0, 1);
        run(1'b1, 3'd2, 4'd1,  12'hFFC, 0, 0);

        // backpressure in DONE with in_valid high and wandering inputs
        @(negedge clk);
        S = 1'b0; E = 3'd3; F = 4'd9; in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 12 && !out_valid; i++) @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            scramble();
            @(negedge clk);
            check("bp_D", 32'(D), 32'h048);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release", 32'(out_valid), 32'd0);
        check("bp_idle", 32'(in_ready), 32'd1);

        // asynchronous reset in the middle of an E=6 shift
        @(negedge clk);
        S = 1'b1; E = 3'd6; F = 4'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_D", 32'(D), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        run(1'b1, 3'd6, 4'd3, 12'hF40, 0, 0);

        for (int s = 0; s < 2; s++)
            for (int e = 0; e < 8; e++)
                for (int f = 0; f < 16; f++)
                    run(1'(s), 3'(e), 4'(f), model(1'(s), 3'(e), 4'(f)),
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
